// File: rtl/sram_master.sv
// Load/store initiator for the byte-enabled, word-organised SRAM port.
// Define SRAM_MASTER_SPLIT_EN to split misaligned accesses in two; otherwise they are rejected.
module sram_master (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        sram_cen_o,
    output logic        sram_wen_o,
    output logic [3:0]  sram_ben_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_din_o,
    input  logic [31:0] sram_dout_i
);

    localparam int unsigned DW = 32;
    localparam int unsigned NB = 4;
`ifdef SRAM_MASTER_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ACC1, S_CAP1, S_ACC2, S_CAP2, S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            sram_cen_q, sram_cen_d;
    logic            sram_wen_q, sram_wen_d;
    logic [NB-1:0]   sram_ben_q, sram_ben_d;
    logic [DW-1:0]   sram_addr_q, sram_addr_d;
    logic [DW-1:0]   sram_din_q, sram_din_d;

    // Request fields held for the whole transaction
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rd1_q;

    logic            accept_c;
    logic            cur_we_c;
    logic [1:0]      cur_size_c;
    logic [DW-1:0]   cur_addr_c;
    logic [DW-1:0]   cur_wdata_c;
    logic [1:0]      off_c;
    logic [NB-1:0]   nmask_c;
    logic [2*NB-1:0] lanes_c;
    logic            misal_c;
    logic            split_c;
    logic            reject_c;
    logic [DW-1:0]   merged_c;
    logic [DW-1:0]   load_c;

    function automatic logic [DW-1:0] rotl32(input logic [DW-1:0] x, input logic [1:0] b);
        logic [2*DW-1:0] d;
        d = {x, x} << {b, 3'b000};
        return d[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] rotr32(input logic [DW-1:0] x, input logic [1:0] b);
        logic [2*DW-1:0] d;
        d = {x, x} >> {b, 3'b000};
        return d[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] extend(input logic [DW-1:0] x, input logic [1:0] sz,
                                             input logic uns);
        logic [DW-1:0] r;
        case (sz)
            2'd0:    r = uns ? {24'h0, x[7:0]}  : {{24{x[7]}}, x[7:0]};
            2'd1:    r = uns ? {16'h0, x[15:0]} : {{16{x[15]}}, x[15:0]};
            default: r = x;
        endcase
        return r;
    endfunction

    // In IDLE the live request describes the access; afterwards the latched copy does
    assign accept_c    = (state_q == S_IDLE) && req_ready_q && req_valid_i;
    assign cur_we_c    = (state_q == S_IDLE) ? req_we_i    : we_q;
    assign cur_size_c  = (state_q == S_IDLE) ? req_size_i  : size_q;
    assign cur_addr_c  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    assign cur_wdata_c = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
    assign off_c       = cur_addr_c[1:0];

    always_comb begin
        case (cur_size_c)
            2'd0:    nmask_c = 4'b0001;
            2'd1:    nmask_c = 4'b0011;
            default: nmask_c = 4'b1111;
        endcase
    end

    // Low nibble: lanes of the first word; high nibble: lanes spilling into the next word
    assign lanes_c  = {4'b0000, nmask_c} << off_c;
    assign misal_c  = |lanes_c[2*NB-1:NB];
    assign split_c  = misal_c && SPLIT_EN;
    assign reject_c = (cur_size_c == 2'd3) || (misal_c && !SPLIT_EN);

    always_comb begin
        merged_c = sram_dout_i;
        if (state_q == S_CAP2) begin
            for (int i = 0; i < int'(NB); i++) begin
                merged_c[8*i +: 8] = (2'(i) >= off_c) ? rd1_q[8*i +: 8] : sram_dout_i[8*i +: 8];
            end
        end
        load_c = extend(rotr32(merged_c, off_c), size_q, uns_q);
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        sram_cen_d  = 1'b1;
        sram_wen_d  = 1'b1;
        sram_ben_d  = 4'hF;
        sram_addr_d = '0;
        sram_din_d  = '0;

        case (state_q)
            S_IDLE: if (accept_c) state_d = reject_c ? S_RESP : S_ACC1;
            S_ACC1: begin
                if (!we_q)        state_d = S_CAP1;
                else if (split_c) state_d = S_ACC2;
                else              state_d = S_RESP;
            end
            S_CAP1:  state_d = split_c ? S_ACC2 : S_RESP;
            S_ACC2:  state_d = we_q ? S_RESP : S_CAP2;
            S_CAP2:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        if (state_q == S_IDLE && accept_c && reject_c) rsp_err_d = 1'b1;
        if (state_d == S_RESP && (state_q == S_CAP1 || state_q == S_CAP2)) rsp_rdata_d = load_c;

        if (state_d == S_ACC1 || state_d == S_ACC2) begin
            sram_cen_d = 1'b0;
            sram_wen_d = ~cur_we_c;
            sram_din_d = rotl32(cur_wdata_c, off_c);
            if (state_d == S_ACC1) begin
                sram_ben_d  = ~lanes_c[NB-1:0];
                sram_addr_d = {cur_addr_c[DW-1:2], 2'b00};
            end else begin
                sram_ben_d  = ~lanes_c[2*NB-1:NB];
                sram_addr_d = {cur_addr_c[DW-1:2], 2'b00} + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            sram_cen_q  <= 1'b1;
            sram_wen_q  <= 1'b1;
            sram_ben_q  <= 4'hF;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd1_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sram_cen_q  <= sram_cen_d;
            sram_wen_q  <= sram_wen_d;
            sram_ben_q  <= sram_ben_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            if (accept_c) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == S_CAP1) rd1_q <= sram_dout_i;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign sram_cen_o  = sram_cen_q;
    assign sram_wen_o  = sram_wen_q;
    assign sram_ben_o  = sram_ben_q;
    assign sram_addr_o = sram_addr_q;
    assign sram_din_o  = sram_din_q;

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with a behavioural byte-enabled SRAM attached.
module tb_sram_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sram_cen, sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr, sram_din, sram_dout;

    logic [31:0] mem [0:255];

    int vectors = 0;
    int miscompares = 0;

    int          acc_n, rsp_cyc, rsp_cnt;
    logic        ready_after;
    logic [3:0]  acc_ben [0:1];
    logic [31:0] acc_addr [0:1];
    logic [31:0] acc_din [0:1];
    logic        acc_wen [0:1];
    logic [31:0] rsp_data;
    logic        rsp_e;

    sram_master dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .sram_cen_o(sram_cen), .sram_wen_o(sram_wen), .sram_ben_o(sram_ben),
        .sram_addr_o(sram_addr), .sram_din_o(sram_din), .sram_dout_i(sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: samples cen at the edge, read data appears the following cycle
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) begin
                for (int i = 0; i < 4; i++)
                    if (!sram_ben[i]) mem[sram_addr[9:2]][8*i +: 8] <= sram_din[8*i +: 8];
            end else begin
                sram_dout <= mem[sram_addr[9:2]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for acceptance, then scramble the inputs
    task automatic send(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0; req_we = ~we; req_size = 2'd2; req_unsigned = ~uns;
        req_addr = 32'h5A5A_5A5B; req_wdata = 32'h0F0F_0F0F;
    endtask

    // Record accesses and the response for 8 cycles starting at cycle 0
    task automatic observe();
        acc_n = 0; rsp_cyc = -1; rsp_cnt = 0; ready_after = 1'b0;
        rsp_data = '0; rsp_e = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!sram_cen) begin
                if (acc_n < 2) begin
                    acc_ben[acc_n] = sram_ben; acc_addr[acc_n] = sram_addr;
                    acc_din[acc_n] = sram_din; acc_wen[acc_n] = sram_wen;
                end
                acc_n++;
            end
            if (rsp_valid) begin
                if (rsp_cnt == 0) begin
                    rsp_cyc = k; rsp_data = rsp_rdata; rsp_e = rsp_err;
                end
                rsp_cnt++;
            end
            if (rsp_cyc >= 0 && k == rsp_cyc + 1) ready_after = req_ready;
            step();
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cen"},   32'(sram_cen),  32'd1);
        chk({tag, "_wen"},   32'(sram_wen),  32'd1);
        chk({tag, "_ben"},   32'(sram_ben),  32'hF);
        chk({tag, "_addr"},  sram_addr,      32'h0);
        chk({tag, "_din"},   sram_din,       32'h0);
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata,      32'h0);
        chk({tag, "_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        sram_dout = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        step(); step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Aligned word store and load
        send(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        observe();
        chk("sw_nacc", 32'(acc_n), 32'd1);
        chk("sw_ben", 32'(acc_ben[0]), 32'h0);
        chk("sw_addr", acc_addr[0], 32'h0000_0100);
        chk("sw_din", acc_din[0], 32'hDEAD_BEEF);
        chk("sw_wen", 32'(acc_wen[0]), 32'd0);
        chk("sw_rspcyc", 32'(rsp_cyc), 32'd1);
        chk("sw_err", 32'(rsp_e), 32'd0);
        chk("sw_rdata", rsp_data, 32'h0);
        chk("sw_rspcnt", 32'(rsp_cnt), 32'd1);
        chk("sw_ready_next", 32'(ready_after), 32'd1);

        send(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        observe();
        chk("lw_nacc", 32'(acc_n), 32'd1);
        chk("lw_wen", 32'(acc_wen[0]), 32'd1);
        chk("lw_ben", 32'(acc_ben[0]), 32'h0);
        chk("lw_rspcyc", 32'(rsp_cyc), 32'd2);
        chk("lw_rdata", rsp_data, 32'hDEAD_BEEF);

        // Byte at offset 3, then signed and unsigned reads
        send(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_0080);
        observe();
        chk("sb_ben", 32'(acc_ben[0]), 32'h7);
        chk("sb_din_lane3", 32'(acc_din[0][31:24]), 32'h80);
        chk("sb_addr", acc_addr[0], 32'h0000_0100);
        send(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0);
        observe();
        chk("lb_signed", rsp_data, 32'hFFFF_FF80);
        send(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0);
        observe();
        chk("lbu", rsp_data, 32'h0000_0080);
        send(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        observe();
        chk("lw_after_sb", rsp_data, 32'h80AD_BEEF);

        // Half at offset 1 stays a single access
        send(1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'h0000_1234);
        observe();
        chk("sh1_nacc", 32'(acc_n), 32'd1);
        chk("sh1_ben", 32'(acc_ben[0]), 32'h9);
        chk("sh1_din", acc_din[0], 32'h0012_3400);
        chk("sh1_rspcyc", 32'(rsp_cyc), 32'd1);
        send(1'b0, 2'd1, 1'b1, 32'h0000_0201, 32'h0);
        observe();
        chk("lh1", rsp_data, 32'h0000_1234);
        chk("lh1_rspcyc", 32'(rsp_cyc), 32'd2);

        // Illegal size
        send(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
        observe();
        chk("sz3_err", 32'(rsp_e), 32'd1);
        chk("sz3_nacc", 32'(acc_n), 32'd0);
        chk("sz3_rspcyc", 32'(rsp_cyc), 32'd0);
        chk("sz3_rdata", rsp_data, 32'h0);

`ifdef SRAM_MASTER_SPLIT_EN
        send(1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'hAABB_CCDD);
        observe();
        chk("ssplit_nacc", 32'(acc_n), 32'd2);
        chk("ssplit_ben0", 32'(acc_ben[0]), 32'h3);
        chk("ssplit_addr0", acc_addr[0], 32'h0000_0300);
        chk("ssplit_ben1", 32'(acc_ben[1]), 32'hC);
        chk("ssplit_addr1", acc_addr[1], 32'h0000_0304);
        chk("ssplit_din", acc_din[0], 32'hCCDD_AABB);
        chk("ssplit_rspcyc", 32'(rsp_cyc), 32'd2);
        chk("ssplit_err", 32'(rsp_e), 32'd0);
        send(1'b0, 2'd2, 1'b0, 32'h0000_0302, 32'h0);
        observe();
        chk("lsplit_nacc", 32'(acc_n), 32'd2);
        chk("lsplit_rspcyc", 32'(rsp_cyc), 32'd4);
        chk("lsplit_rdata", rsp_data, 32'hAABB_CCDD);
        chk("lsplit_ready_next", 32'(ready_after), 32'd1);

        send(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1122_3344);
        observe();
        chk("wrap_addr0", acc_addr[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", acc_addr[1], 32'h0000_0000);
        chk("wrap_ben1", 32'(acc_ben[1]), 32'hC);
`else
        send(1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'hAABB_CCDD);
        observe();
        chk("rej_err", 32'(rsp_e), 32'd1);
        chk("rej_nacc", 32'(acc_n), 32'd0);
        chk("rej_rspcyc", 32'(rsp_cyc), 32'd0);
        send(1'b0, 2'd1, 1'b0, 32'h0000_0203, 32'h0);
        observe();
        chk("rej_h3_err", 32'(rsp_e), 32'd1);
        chk("rej_h3_rdata", rsp_data, 32'h0);
        chk("rej_h3_nacc", 32'(acc_n), 32'd0);
`endif

        // Reset during CAP1 of a load
        send(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        chk("mid_acc1_cen", 32'(sram_cen), 32'd0);
        step();
        rst_n = 1'b0;
        step();
        chk_idle_outputs("mid_reset");
        step();
        chk("mid_reset_rspv2", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_release_rspv", 32'(rsp_valid), 32'd0);
        chk("mid_release_cen", 32'(sram_cen), 32'd1);
        chk("mid_release_ready", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
